// File: rtl/feedback_frame_receiver.sv
// Receive-side frame assembler for the game-client UART link.
// A feedback byte (tag 2'b11) is held pending until its game-state byte
// (tag 2'b01) arrives; both are then published together on one edge, so
// downstream logic never observes a half-updated frame. Echo bytes
// (tags 2'b00 / 2'b10) are ignored. A link that goes without a committed
// frame for STALE_CYCLES is flagged stale and sig_front is pulled low.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready/backpressure, every strobed byte is consumed in its own cycle, and
// strobes may arrive on consecutive cycles. feedback_valid and frame_error
// are one-cycle pulses that follow the byte cycle by one edge.
module feedback_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned STALE_CYCLES   = 100000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] data_game_state,
  output logic       sig_front,
  output logic       sig_hand,
  output logic       sig_processing,
  output logic       sig_machine,
  output logic       feedback_valid,
  output logic       frame_error,
  output logic       link_stale
);

  typedef enum logic {
    S_IDLE       = 1'b0,
    S_WAIT_STATE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  state_t           r_state;
  logic [3:0]       r_pending;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_stale_cnt;
  logic [7:0]       r_game_state;
  logic             r_front;
  logic             r_hand;
  logic             r_processing;
  logic             r_machine;
  logic             r_fb_valid;
  logic             r_frame_err;
  logic             r_link_stale;

  logic             w_is_fb;
  logic             w_is_gs;
  logic             w_fb_ok;
  logic             w_commit;
  logic [CNT_W-1:0] w_stale_next;
  logic             w_stale_hit;

  // Byte classification and commit / stale detection for this cycle.
  assign w_is_fb  = rx_valid && (rx_data[1:0] == 2'b11);
  assign w_is_gs  = rx_valid && (rx_data[1:0] == 2'b01);
  assign w_fb_ok  = (rx_data[7:6] == 2'b00);
  assign w_commit = (r_state == S_WAIT_STATE) && w_is_gs;

  // Stale counter saturates at the threshold; a commit always clears it,
  // which is what lets a commit win over a simultaneous threshold crossing.
  assign w_stale_next = w_commit                   ? '0 :
                        (r_stale_cnt == STALE_MAX) ? STALE_MAX :
                                                     r_stale_cnt + CNT_W'(1);
  assign w_stale_hit  = !w_commit && (w_stale_next == STALE_MAX);

  // Link-liveness counter and the stale flag.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      r_stale_cnt  <= '0;
      r_link_stale <= 1'b0;
    end else begin
      r_stale_cnt  <= w_stale_next;
      r_link_stale <= w_stale_hit;
    end
  end

  // Frame FSM: pending capture, timeout, commit and error pulses.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= 4'b0000;
      r_to_cnt     <= '0;
      r_game_state <= 8'h00;
      r_front      <= 1'b0;
      r_hand       <= 1'b0;
      r_processing <= 1'b0;
      r_machine    <= 1'b0;
      r_fb_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_fb_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_fb) begin
            if (w_fb_ok) begin
              r_pending <= rx_data[5:2];
              r_to_cnt  <= '0;
              r_state   <= S_WAIT_STATE;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_is_gs) begin
            // Orphan game-state byte: nothing to pair it with.
            r_frame_err <= 1'b1;
          end
        end
        S_WAIT_STATE: begin
          if (w_is_gs) begin
            r_game_state <= rx_data;
            r_front      <= r_pending[0];
            r_hand       <= r_pending[1];
            r_processing <= r_pending[2];
            r_machine    <= r_pending[3];
            r_fb_valid   <= 1'b1;
            r_pending    <= 4'b0000;
            r_state      <= S_IDLE;
          end else if (w_is_fb) begin
            r_frame_err <= 1'b1;
            if (w_fb_ok) begin
              // A newer feedback byte replaces the unpaired one.
              r_pending <= rx_data[5:2];
              r_to_cnt  <= '0;
            end else begin
              r_pending <= 4'b0000;
              r_state   <= S_IDLE;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_frame_err <= 1'b1;
            r_pending   <= 4'b0000;
            r_to_cnt    <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Losing the link blocks non-move operates by dropping sig_front.
      if (w_stale_hit) begin
        r_front <= 1'b0;
      end
    end
  end

  assign data_game_state = r_game_state;
  assign sig_front       = r_front;
  assign sig_hand        = r_hand;
  assign sig_processing  = r_processing;
  assign sig_machine     = r_machine;
  assign feedback_valid  = r_fb_valid;
  assign frame_error     = r_frame_err;
  assign link_stale      = r_link_stale;

endmodule

// File: tb/tb_feedback_frame_receiver.sv
// Bench for feedback_frame_receiver: directed scenarios followed by random
// byte streams of varying density, checked every cycle against a
// frame-level reference model and a commit scoreboard.
module tb_feedback_frame_receiver;

  localparam int T  = 8;
  localparam int S  = 40;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic       uart_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;

  logic [7:0] data_game_state;
  logic       sig_front, sig_hand, sig_processing, sig_machine;
  logic       feedback_valid, frame_error, link_stale;

  always #5 uart_clk = ~uart_clk;

  feedback_frame_receiver #(
    .TIMEOUT_CYCLES(T),
    .STALE_CYCLES  (S),
    .CNT_W         (CW)
  ) dut (
    .uart_clk       (uart_clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .data_game_state(data_game_state),
    .sig_front      (sig_front),
    .sig_hand       (sig_hand),
    .sig_processing (sig_processing),
    .sig_machine    (sig_machine),
    .feedback_valid (feedback_valid),
    .frame_error    (frame_error),
    .link_stale     (link_stale)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: {game_state, machine, processing, hand, front} per commit.
  logic [11:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [7:0] m_gs;
  logic [3:0] m_sig;     // {machine, processing, hand, front}
  logic       m_fbv, m_err, m_stale;
  logic       m_have_pend;
  logic [3:0] m_pend;
  int         m_age;     // cycles since the pending feedback byte
  int         m_since;   // cycles since last commit or reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic fb, gs, commit;
    if (!rst_n) begin
      m_gs = 8'h00; m_sig = 4'h0; m_fbv = 1'b0; m_err = 1'b0; m_stale = 1'b0;
      m_have_pend = 1'b0; m_pend = 4'h0; m_age = 0; m_since = 0;
      return;
    end
    m_fbv  = 1'b0;
    m_err  = 1'b0;
    commit = 1'b0;
    fb = v && (d[1:0] == 2'b11);
    gs = v && (d[1:0] == 2'b01);
    if (m_have_pend) m_age++;
    if (fb) begin
      if (d[7:6] != 2'b00) begin
        m_err = 1'b1;
        m_have_pend = 1'b0;
      end else begin
        if (m_have_pend) m_err = 1'b1;
        m_have_pend = 1'b1;
        m_pend = d[5:2];
        m_age = 0;
      end
    end else if (gs) begin
      if (m_have_pend) begin
        commit = 1'b1;
        m_gs = d;
        m_sig = m_pend;
        m_fbv = 1'b1;
        m_have_pend = 1'b0;
        exp_q.push_back({d, m_pend});
      end else begin
        m_err = 1'b1;
      end
    end else if (m_have_pend && m_age == T) begin
      m_err = 1'b1;
      m_have_pend = 1'b0;
    end
    if (commit) m_since = 0;
    else if (m_since < S) m_since++;
    m_stale = (m_since >= S);
    if (m_stale) m_sig[0] = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [7:0] d, input string tag);
    rx_valid = v;
    rx_data  = d;
    @(posedge uart_clk);
    #1;
    model_step(v, d);
    check(tag,
          {data_game_state, sig_machine, sig_processing, sig_hand, sig_front,
           feedback_valid, frame_error, link_stale},
          {m_gs, m_sig, m_fbv, m_err, m_stale});
    check("fv_err_excl", feedback_valid & frame_error, 0);
    if (feedback_valid) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("sb_payload",
              {data_game_state, sig_machine, sig_processing, sig_hand, sig_front},
              exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), "idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, "reset");
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    logic [7:0] b;
    k = $urandom_range(0, 9);
    b = 8'($urandom);
    if (k <= 3) begin
      b = {2'b00, b[5:2], 2'b11};
    end else if (k == 4) begin
      if (b[7:6] == 2'b00) b[7:6] = 2'b10;
      b[1:0] = 2'b11;
    end else if (k <= 7) begin
      b[1:0] = 2'b01;
    end else begin
      b[0] = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [3:0] dut_sigs();
    return {sig_machine, sig_processing, sig_hand, sig_front};
  endfunction

  // ---------------- test sequence ----------------
  int dens[6] = '{80, 40, 15, 5, 60, 2};

  initial begin
    do_reset();
    check("rst_vals",
          {data_game_state, dut_sigs(), feedback_valid, frame_error, link_stale}, 0);

    // Basic frame.
    cycle(1'b1, 8'h2F, "tp1_fb");
    cycle(1'b1, 8'h05, "tp1_gs");
    check("tp1_gs_val", data_game_state, 8'h05);
    check("tp1_sig", dut_sigs(), 4'b1011);
    check("tp1_fv", feedback_valid, 1);
    idle(1);
    check("tp1_fv_once", feedback_valid, 0);

    // Orphan game-state byte.
    do_reset();
    cycle(1'b1, 8'h09, "tp2_orphan");
    check("tp2_err", frame_error, 1);
    check("tp2_gs", data_game_state, 8'h00);
    check("tp2_fv", feedback_valid, 0);

    // Timeout, then the late byte becomes an orphan.
    do_reset();
    cycle(1'b1, 8'h07, "tp3_fb");
    idle(T - 1);
    check("tp3_no_early", frame_error, 0);
    idle(1);
    check("tp3_timeout", frame_error, 1);
    cycle(1'b1, 8'h05, "tp3_late");
    check("tp3_orphan", frame_error, 1);
    check("tp3_sig", dut_sigs(), 4'b0000);
    check("tp3_gs", data_game_state, 8'h00);

    // Game-state byte on the exact timeout cycle still commits.
    do_reset();
    cycle(1'b1, 8'h07, "tp3b_fb");
    idle(T - 1);
    cycle(1'b1, 8'h05, "tp3b_gs");
    check("tp3b_fv", feedback_valid, 1);
    check("tp3b_err", frame_error, 0);

    // Replaced feedback byte, back-to-back strobes.
    do_reset();
    cycle(1'b1, 8'h07, "tp4_fb1");
    cycle(1'b1, 8'h0B, "tp4_fb2");
    check("tp4_err", frame_error, 1);
    cycle(1'b1, 8'h01, "tp4_gs");
    check("tp4_fv", feedback_valid, 1);
    check("tp4_sig", dut_sigs(), 4'b0010);
    check("tp4_gs_val", data_game_state, 8'h01);

    // Stale link.
    do_reset();
    cycle(1'b1, 8'h0F, "tp5_fb");
    cycle(1'b1, 8'h05, "tp5_gs");
    check("tp5_front", sig_front, 1);
    idle(S - 1);
    check("tp5_not_yet", link_stale, 0);
    idle(1);
    check("tp5_stale", link_stale, 1);
    check("tp5_front0", sig_front, 0);
    check("tp5_hand", sig_hand, 1);
    check("tp5_gs_held", data_game_state, 8'h05);
    cycle(1'b1, 8'h07, "tp5_fb2");
    cycle(1'b1, 8'h05, "tp5_gs2");
    check("tp5_unstale", link_stale, 0);
    check("tp5_front1", sig_front, 1);

    // Reset mid-frame discards the pending byte.
    do_reset();
    cycle(1'b1, 8'h07, "tp6_fb");
    do_reset();
    cycle(1'b1, 8'h05, "tp6_gs");
    check("tp6_err", frame_error, 1);
    check("tp6_fv", feedback_valid, 0);
    check("tp6_out",
          {data_game_state, dut_sigs()}, 0);

    // Random streams at several strobe densities.
    foreach (dens[p]) begin
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 999) == 0) begin
          do_reset();
        end else if ($urandom_range(1, 100) <= dens[p]) begin
          cycle(1'b1, rand_byte(), "rand");
        end else begin
          cycle(1'b0, 8'($urandom), "rand_idle");
        end
      end
    end

    idle(2);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
